// File: rtl/track_ctrl.sv
// track_ctrl: upstream sequencer for the motor stage.
// Filters the three IR line sensors on a 1 ms tick, runs the start countdown,
// line following with left/right correction, junction handling through a
// valid/ack handshake with the path planner, and lost-line handling. The
// registered 5-bit mode code tells the motor stage what to do.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset (0 = reset)
//   start        start button, already synchronised; acted on at its rising edge
//   sensor[2:0]  {L,M,R}, 1 = line under the sensor
//   route_valid  planner holds a junction decision
//   route[1:0]   00 straight, 01 left, 10 right, 11 stop
//   route_ack    one-cycle pulse when a route is consumed (CHOOSE only)
//   mode[4:0]    IDLE 0, START 1, COUNT 2, STRAIGHT 3, CHOOSE 4, LEFT 5,
//                RIGHT 6, BACK 7, STOP 8, ERROR 31
//
// Build option: TRACK_CTRL_LOST_RECOVERY_EN
//   defined   : a lost line enters BACK (reverse for BACK_MS) before giving up
//   undefined : a lost line goes straight to ERROR; BACK is never entered
module track_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int DEBOUNCE  = 4,
  parameter int COUNT_MS  = 3000,
  parameter int TURN_MS   = 400,
  parameter int CHOOSE_MS = 1000,
  parameter int LOST_MS   = 500,
  parameter int BACK_MS   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] sensor,
  input  logic       route_valid,
  input  logic [1:0] route,
  output logic       route_ack,
  output logic [4:0] mode
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(DEBOUNCE + 1);
  localparam int TW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_COUNT, S_FOLLOW, S_CORR_L, S_CORR_R, S_CHOOSE,
    S_TURN_L, S_TURN_R, S_BACK, S_STOP, S_ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [TW-1:0]   lost_cnt;
  logic            ack_nxt;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic [2:0]      last, filt;
  logic [FW-1:0]   same_cnt, same_nxt;
  logic            start_q, start_edge;
  logic            following, lost_hit;

  // 1 ms tick
  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Debounce: count consecutive equal tick samples, saturating at DEBOUNCE
  always_comb begin
    if (sensor != last)                same_nxt = FW'(1);
    else if (same_cnt == FW'(DEBOUNCE)) same_nxt = same_cnt;
    else                               same_nxt = same_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last     <= '0;
      same_cnt <= '0;
      filt     <= '0;
    end else if (tick) begin
      last     <= sensor;
      same_cnt <= same_nxt;
      if (same_nxt == FW'(DEBOUNCE)) filt <= sensor;
    end
  end

  assign start_edge = start & ~start_q;

  always_ff @(posedge clk) begin
    if (!rst) start_q <= 1'b0;
    else      start_q <= start;
  end

  // Lost-line timer: counts ticks of filt==000 while tracking the line
  assign following = (state == S_FOLLOW) || (state == S_CORR_L) || (state == S_CORR_R);
  assign lost_hit  = tick && (filt == 3'b000) && (lost_cnt == TW'(LOST_MS - 1));

  always_ff @(posedge clk) begin
    if (!rst)                             lost_cnt <= '0;
    else if (!following || filt != 3'b000) lost_cnt <= '0;
    else if (tick)                        lost_cnt <= lost_cnt + 1'b1;
  end

  function automatic logic [4:0] mode_of(input state_t s);
    case (s)
      S_IDLE:            mode_of = 5'd0;
      S_START:           mode_of = 5'd1;
      S_COUNT:           mode_of = 5'd2;
      S_FOLLOW:          mode_of = 5'd3;
      S_CHOOSE:          mode_of = 5'd4;
      S_CORR_L, S_TURN_L: mode_of = 5'd5;
      S_CORR_R, S_TURN_R: mode_of = 5'd6;
      S_BACK:            mode_of = 5'd7;
      S_STOP:            mode_of = 5'd8;
      default:           mode_of = 5'd31;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    timer_nxt = (tick && timer != '0) ? timer - 1'b1 : timer;
    ack_nxt   = 1'b0;
    case (state)
      S_IDLE: if (start_edge) state_nxt = S_START;
      S_START: begin
        state_nxt = S_COUNT;
        timer_nxt = TW'(COUNT_MS);
      end
      S_COUNT: if (timer == '0) state_nxt = S_FOLLOW;
      S_FOLLOW, S_CORR_L, S_CORR_R: begin
        if (filt == 3'b111) begin
          state_nxt = S_CHOOSE;
          timer_nxt = TW'(CHOOSE_MS);
        end else if (lost_hit) begin
`ifdef TRACK_CTRL_LOST_RECOVERY_EN
          state_nxt = S_BACK;
          timer_nxt = TW'(BACK_MS);
`else
          state_nxt = S_ERROR;
`endif
        end else if (state == S_FOLLOW) begin
          case (filt)
            3'b100, 3'b110: state_nxt = S_CORR_L;
            3'b001, 3'b011: state_nxt = S_CORR_R;
            default:        state_nxt = S_FOLLOW;
          endcase
        end else if (filt == 3'b010) begin
          state_nxt = S_FOLLOW;
        end
      end
      S_CHOOSE: begin
        if (route_valid) begin
          ack_nxt = 1'b1;
          case (route)
            2'b00: state_nxt = S_FOLLOW;
            2'b01: begin state_nxt = S_TURN_L; timer_nxt = TW'(TURN_MS); end
            2'b10: begin state_nxt = S_TURN_R; timer_nxt = TW'(TURN_MS); end
            default: state_nxt = S_STOP;
          endcase
        end else if (timer == '0) begin
          state_nxt = S_ERROR;
        end
      end
      S_TURN_L, S_TURN_R: if (timer == '0 && filt[1]) state_nxt = S_FOLLOW;
`ifdef TRACK_CTRL_LOST_RECOVERY_EN
      S_BACK: begin
        if (filt != 3'b000)    state_nxt = S_FOLLOW;
        else if (timer == '0) state_nxt = S_ERROR;
      end
`endif
      S_STOP, S_ERROR: if (start_edge) state_nxt = S_IDLE;
      default: state_nxt = S_ERROR;
    endcase
  end

  // mode and route_ack are registered alongside the state they describe
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      mode      <= 5'd0;
      route_ack <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      mode      <= mode_of(state_nxt);
      route_ack <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_track_ctrl.sv
// tb_track_ctrl: directed, table-driven bench for track_ctrl using short
// timing parameters (1 tick = 10 clk). Each table record holds inputs, a
// cycle count to run them for, and the mode/route_ack expected afterwards;
// hold counts leave margin for the unknown tick phase. The lost-line
// sequence is hand-written because it branches on TRACK_CTRL_LOST_RECOVERY_EN.
module tb_track_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] sensor = 3'b010;
  logic       route_valid = 1'b0;
  logic [1:0] route = 2'b00;
  logic       route_ack;
  logic [4:0] mode;

  track_ctrl #(
    .TICK_DIV(10), .DEBOUNCE(2), .COUNT_MS(5), .TURN_MS(3),
    .CHOOSE_MS(8), .LOST_MS(4), .BACK_MS(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sensor(sensor),
    .route_valid(route_valid), .route(route),
    .route_ack(route_ack), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       s;
    logic [2:0] sn;
    logic       v;
    logic [1:0] rt;
    int         cyc;
    logic [4:0] m;
    logic       a;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;
  int   ack_cnt = 0;
  int   saw7 = 0;

  always @(negedge clk) begin
    if (route_ack === 1'b1) ack_cnt++;
    if (mode === 5'd7) saw7 = 1;
  end

  task automatic addv(input logic r, input logic s, input logic [2:0] sn,
                      input logic v, input logic [1:0] rt, input int cyc,
                      input logic [4:0] m, input logic a, input string nm);
    vec_t t;
    t.r = r; t.s = s; t.sn = sn; t.v = v; t.rt = rt;
    t.cyc = cyc; t.m = m; t.a = a; t.nm = nm;
    vecs.push_back(t);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_change(input logic [4:0] from, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step(1);
      n++;
      if (mode != from) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
    $fatal(1);
  end

  initial begin
    int n;
    //   rst  st  sensor  rv  route  cyc  mode  ack  name
    addv(0, 0, 3'b010, 0, 2'b00,  3,  0, 0, "reset");
    addv(1, 0, 3'b010, 0, 2'b00, 20,  0, 0, "idle_hold");
    addv(1, 1, 3'b010, 0, 2'b00,  1,  1, 0, "start");
    addv(1, 0, 3'b010, 0, 2'b00,  1,  2, 0, "count_enter");
    addv(1, 0, 3'b010, 0, 2'b00, 30,  2, 0, "count_hold");
    addv(1, 0, 3'b010, 0, 2'b00, 30,  3, 0, "follow");
    addv(1, 1, 3'b010, 0, 2'b00,  5,  3, 0, "start_ignored");
    addv(1, 0, 3'b110, 0, 2'b00, 25,  5, 0, "corr_l");
    addv(1, 0, 3'b010, 0, 2'b00, 25,  3, 0, "corr_l_exit");
    addv(1, 0, 3'b001, 0, 2'b00, 25,  6, 0, "corr_r");
    addv(1, 0, 3'b011, 0, 2'b00, 25,  6, 0, "corr_r_hold");
    addv(1, 0, 3'b010, 0, 2'b00, 25,  3, 0, "corr_r_exit");
    addv(1, 0, 3'b101, 0, 2'b00, 25,  3, 0, "hold_101");
    addv(1, 0, 3'b010, 1, 2'b11, 20,  3, 0, "rv_ignored");
    addv(1, 0, 3'b111, 0, 2'b00, 25,  4, 0, "choose");
    addv(1, 0, 3'b100, 1, 2'b01,  1,  5, 1, "ack_left");
    addv(1, 0, 3'b100, 0, 2'b00,  1,  5, 0, "ack_left_drop");
    addv(1, 0, 3'b100, 0, 2'b00, 28,  5, 0, "turn_l_blind");
    addv(1, 0, 3'b010, 0, 2'b00, 30,  3, 0, "turn_l_exit");
    addv(1, 0, 3'b111, 0, 2'b00, 25,  4, 0, "choose_r");
    addv(1, 0, 3'b001, 1, 2'b10,  1,  6, 1, "ack_right");
    addv(1, 0, 3'b001, 0, 2'b00, 29,  6, 0, "turn_r_blind");
    addv(1, 0, 3'b010, 0, 2'b00, 30,  3, 0, "turn_r_exit");
    addv(1, 0, 3'b111, 0, 2'b00, 25,  4, 0, "choose_to");
    addv(1, 0, 3'b111, 0, 2'b00, 50,  4, 0, "choose_wait");
    addv(1, 0, 3'b111, 0, 2'b00, 40, 31, 0, "choose_timeout");
    addv(1, 1, 3'b111, 0, 2'b00,  1,  0, 0, "error_restart");
    addv(1, 0, 3'b010, 0, 2'b00,  1,  0, 0, "idle_again");
    addv(1, 1, 3'b010, 0, 2'b00,  1,  1, 0, "start2");
    addv(1, 0, 3'b010, 0, 2'b00, 60,  3, 0, "follow2");
    addv(1, 0, 3'b111, 0, 2'b00, 25,  4, 0, "choose_stop");
    addv(1, 0, 3'b111, 1, 2'b11,  1,  8, 1, "ack_stop");
    addv(1, 0, 3'b010, 0, 2'b00, 20,  8, 0, "stop_sticky");
    addv(1, 1, 3'b010, 0, 2'b00,  1,  0, 0, "stop_restart");
    addv(1, 0, 3'b010, 0, 2'b00,  1,  0, 0, "idle3");
    addv(1, 1, 3'b010, 0, 2'b00,  1,  1, 0, "start3");
    addv(1, 0, 3'b010, 0, 2'b00, 60,  3, 0, "follow3");
    addv(0, 0, 3'b010, 1, 2'b01,  1,  0, 0, "reset_mid");
    addv(1, 0, 3'b010, 0, 2'b00, 20,  0, 0, "reset_hold");

    foreach (vecs[i]) begin
      rst = vecs[i].r; start = vecs[i].s; sensor = vecs[i].sn;
      route_valid = vecs[i].v; route = vecs[i].rt;
      step(vecs[i].cyc);
      nvec++;
      if (mode !== vecs[i].m || route_ack !== vecs[i].a) begin
        nerr++;
        $display("FAIL %s: mode=%0d ack=%b, expected mode=%0d ack=%b",
                 vecs[i].nm, mode, route_ack, vecs[i].m, vecs[i].a);
      end
    end

    // Lost line: filt goes 000 within 11..21 clk, then 4 more ticks
    start = 1'b1; step(1);
    start = 1'b0; step(60);
    chk("lost_pre_follow", mode, 3);
    sensor = 3'b000;
    wait_change(5'd3, 100, n);
    chk("lost_latency_in_window", (n >= 45 && n <= 65) ? 1 : 0, 1);
`ifdef TRACK_CTRL_LOST_RECOVERY_EN
    chk("lost_back", mode, 7);
    sensor = 3'b010;
    step(25);
    chk("back_recover", mode, 3);
    sensor = 3'b000;
    wait_change(5'd3, 100, n);
    chk("lost_back2", mode, 7);
    step(40);
    chk("back_expire", mode, 31);
`else
    chk("lost_error", mode, 31);
    sensor = 3'b010;
    step(20);
    chk("lost_sticky", mode, 31);
    chk("never_back", saw7, 0);
`endif
    chk("ack_pulse_count", ack_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
